// File: rtl/pll_lock_monitor.sv
// PLL lock monitor: holds the system in reset until the PLL has locked,
// settled, and its output frequency measures in range against clk.
module pll_lock_monitor #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1024,
  parameter int WINDOW_CYCLES = 1024,
  parameter int EDGES_MIN     = 376,
  parameter int EDGES_MAX     = 392,
  parameter int FAULT_HOLD    = 256,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pll_lock,
  input  logic             pll_tick,
  output logic             sys_rst,
  output logic             ready,
  output logic [7:0]       fault_count,
  output logic [CNT_W-1:0] last_edges,
  output logic [2:0]       state_dbg
);

  localparam int NS =
    (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int TMAX =
    (STABLE_CYCLES > FAULT_HOLD) ?
    STABLE_CYCLES : FAULT_HOLD;
  localparam int TMR_W = $clog2(TMAX + 1);
  localparam int WIN_W =
    (WINDOW_CYCLES > 1) ?
    $clog2(WINDOW_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_HOLD    = 3'd0,
    S_SETTLE  = 3'd1,
    S_MEASURE = 3'd2,
    S_RUN     = 3'd3,
    S_FAULT   = 3'd4
  } state_t;

  logic [NS-1:0]    lock_sync;
  logic [NS-1:0]    tick_sync;
  logic             tick_d;
  logic             lock_s;
  logic             tick_s;
  logic             tick_e;

  state_t           state;
  state_t           next;

  logic [TMR_W-1:0] tmr;
  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] edge_cnt;
  logic [CNT_W-1:0] edge_total;
  logic [CNT_W-1:0] tick_inc;

  logic             counting;
  logic             win_end;
  logic             in_range;
  logic             enter_fault;
  logic             timed;
  logic             stable_done;
  logic             hold_done;

  assign lock_s = lock_sync[NS-1];
  assign tick_s = tick_sync[NS-1];
  assign tick_e = tick_s ^ tick_d;

  // Bring lock and tick into clk; extra tick flop gives both edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_sync <= '0;
      tick_sync <= '0;
      tick_d    <= 1'b0;
    end else begin
      lock_sync <= {lock_sync[NS-2:0], pll_lock};
      tick_sync <= {tick_sync[NS-2:0], pll_tick};
      tick_d    <= tick_s;
    end
  end

  assign counting =
    (state == S_MEASURE) || (state == S_RUN);

  assign win_end = counting &&
    (win_cnt == WIN_W'(WINDOW_CYCLES - 1));

  assign tick_inc =
    {{(CNT_W-1){1'b0}}, tick_e};

  // Saturating total including this cycle's edge.
  assign edge_total = (&edge_cnt) ?
    edge_cnt : (edge_cnt + tick_inc);

  assign in_range =
    (edge_total >= CNT_W'(EDGES_MIN)) &&
    (edge_total <= CNT_W'(EDGES_MAX));

  // Window and edge counters; idle outside MEASURE and RUN.
  always_ff @(posedge clk) begin
    if (rst || !counting) begin
      win_cnt  <= '0;
      edge_cnt <= '0;
    end else if (win_end) begin
      win_cnt  <= '0;
      edge_cnt <= '0;
    end else begin
      win_cnt  <= win_cnt + WIN_W'(1);
      edge_cnt <= edge_total;
    end
  end

  // Capture the total of each completed window.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_edges <= '0;
    end else if (win_end) begin
      last_edges <= edge_total;
    end
  end

  assign timed =
    (state == S_SETTLE) || (state == S_FAULT);

  assign stable_done =
    (tmr == TMR_W'(STABLE_CYCLES - 1));

  assign hold_done =
    (tmr == TMR_W'(FAULT_HOLD - 1));

  // Dwell timer for SETTLE and FAULT, restarted on every state change.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmr <= '0;
    end else if (next != state) begin
      tmr <= '0;
    end else if (timed) begin
      tmr <= tmr + TMR_W'(1);
    end else begin
      tmr <= '0;
    end
  end

  // Next-state logic.
  always_comb begin
    next = state;
    unique case (state)
      S_HOLD: begin
        if (lock_s) begin
          next = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (!lock_s) begin
          next = S_HOLD;
        end else if (stable_done) begin
          next = S_MEASURE;
        end
      end
      S_MEASURE: begin
        if (!lock_s) begin
          next = S_HOLD;
        end else if (win_end) begin
          next = in_range ? S_RUN : S_FAULT;
        end
      end
      S_RUN: begin
        if (!lock_s) begin
          next = S_FAULT;
        end else if (win_end && !in_range) begin
          next = S_FAULT;
        end
      end
      S_FAULT: begin
        if (hold_done) begin
          next = S_HOLD;
        end
      end
      default: begin
        next = S_HOLD;
      end
    endcase
  end

  assign enter_fault =
    (next == S_FAULT) && (state != S_FAULT);

  // State plus outputs registered from next-state so they move together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_HOLD;
      sys_rst     <= 1'b1;
      ready       <= 1'b0;
      fault_count <= 8'd0;
    end else begin
      state   <= next;
      sys_rst <= (next != S_RUN);
      ready   <= (next == S_RUN);
      if (enter_fault && (fault_count != 8'hFF)) begin
        fault_count <= fault_count + 8'd1;
      end
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Bench for pll_lock_monitor: directed scenarios plus randomized
// lock/frequency traffic compared against a behavioural model.
module tb_pll_lock_monitor;

  localparam int SYNC   = 2;
  localparam int STABLE = 16;
  localparam int WIN    = 64;
  localparam int EMIN   = 20;
  localparam int EMAX   = 28;
  localparam int FH     = 8;
  localparam int CW     = 16;
  localparam int LAT    = SYNC + STABLE + WIN + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pll_lock = 1'b0;
  logic          pll_tick = 1'b0;
  logic          sys_rst;
  logic          ready;
  logic [7:0]    fault_count;
  logic [CW-1:0] last_edges;
  logic [2:0]    state_dbg;

  int total = 0;
  int bad = 0;
  int rate = 24;
  int acc = 0;

  pll_lock_monitor #(
    .SYNC_STAGES(SYNC),
    .STABLE_CYCLES(STABLE),
    .WINDOW_CYCLES(WIN),
    .EDGES_MIN(EMIN),
    .EDGES_MAX(EMAX),
    .FAULT_HOLD(FH),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pll_lock(pll_lock),
    .pll_tick(pll_tick),
    .sys_rst(sys_rst),
    .ready(ready),
    .fault_count(fault_count),
    .last_edges(last_edges),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Tick source: exactly `rate` toggles in any WIN consecutive cycles.
  always @(negedge clk) begin
    acc = acc + rate;
    if (acc >= WIN) begin
      acc = acc - WIN;
      pll_tick = ~pll_tick;
    end
  end

  // Reference model: history queues stand in for synchronizer delay.
  bit lh[$] = '{1'b0, 1'b0};
  bit th[$] = '{1'b0, 1'b0, 1'b0};
  int m_st = 0;
  int m_run = 0;
  int m_f = 0;
  int m_wpos = 0;
  int m_edges = 0;
  int m_last = 0;
  int m_faults = 0;

  always @(posedge clk) begin : model
    int nxt;
    bit ls;
    bit te;
    bit we;
    bit inr;
    if (rst) begin
      lh = '{1'b0, 1'b0};
      th = '{1'b0, 1'b0, 1'b0};
      m_st = 0;
      m_run = 0;
      m_f = 0;
      m_wpos = 0;
      m_edges = 0;
      m_last = 0;
      m_faults = 0;
    end else begin
      ls = lh[0];
      te = th[1] ^ th[0];
      we = 1'b0;
      nxt = m_st;
      if (m_st == 2 || m_st == 3) begin
        if (te && m_edges < 65535) m_edges++;
        m_wpos++;
        if (m_wpos == WIN) begin
          we = 1'b1;
          m_last = m_edges;
        end
      end
      inr = (m_last >= EMIN) && (m_last <= EMAX);
      case (m_st)
        0: if (ls) begin nxt = 1; m_run = 0; end
        1: begin
          if (!ls) nxt = 0;
          else begin
            m_run++;
            if (m_run == STABLE) nxt = 2;
          end
        end
        2: begin
          if (!ls) nxt = 0;
          else if (we) nxt = inr ? 3 : 4;
        end
        3: if (!ls || (we && !inr)) nxt = 4;
        default: begin
          m_f++;
          if (m_f == FH) nxt = 0;
        end
      endcase
      if (nxt == 4 && m_st != 4) begin
        m_f = 0;
        if (m_faults < 255) m_faults++;
      end
      if (we || nxt < 2 || nxt == 4) begin
        m_wpos = 0;
        m_edges = 0;
      end
      m_st = nxt;
      lh.push_back(pll_lock);
      void'(lh.pop_front());
      th.push_back(pll_tick);
      void'(th.pop_front());
    end
  end

  // Waits until (state_dbg == s) equals want; n = cycles, or -1 on timeout.
  task automatic wait_state(input logic [2:0] s, input bit want,
                            input int lim, output int n);
    n = -1;
    for (int i = 1; i <= lim; i++) begin
      @(negedge clk);
      if ((state_dbg == s) == want) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pll_lock = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if (sys_rst !== 1'b1) begin
      bad++; $display("FAIL reset_sys_rst got=%0b want=1", sys_rst);
    end
    total++;
    if (ready !== 1'b0) begin
      bad++; $display("FAIL reset_ready got=%0b want=0", ready);
    end
    total++;
    if (fault_count !== 8'd0) begin
      bad++; $display("FAIL reset_faults got=%0d want=0", fault_count);
    end
    total++;
    if (last_edges !== '0) begin
      bad++; $display("FAIL reset_last got=%0d want=0", last_edges);
    end
    total++;
    if (state_dbg !== 3'd0) begin
      bad++; $display("FAIL reset_state got=%0d want=0", state_dbg);
    end
    rst = 1'b0;
  endtask

  task automatic test_clean_start();
    int n;
    rate = 24;
    pll_lock = 1'b1;
    wait_state(3'd3, 1'b1, 300, n);
    total++;
    if (n != LAT) begin
      bad++; $display("FAIL clean_latency got=%0d want=%0d", n, LAT);
    end
    total++;
    if (sys_rst !== 1'b0 || ready !== 1'b1) begin
      bad++;
      $display("FAIL clean_outputs got sys_rst=%0b ready=%0b want 0/1",
               sys_rst, ready);
    end
    total++;
    if (last_edges !== 16'd24) begin
      bad++; $display("FAIL clean_last got=%0d want=24", last_edges);
    end
    total++;
    if (fault_count !== 8'd0) begin
      bad++; $display("FAIL clean_faults got=%0d want=0", fault_count);
    end
  endtask

  task automatic test_lock_glitch();
    int n;
    rst = 1'b1;
    pll_lock = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pll_lock = 1'b1;
    wait_state(3'd1, 1'b1, 20, n);
    total++;
    if (n != SYNC + 1) begin
      bad++; $display("FAIL glitch_settle_entry got=%0d want=%0d", n, SYNC + 1);
    end
    repeat (9) @(negedge clk);
    pll_lock = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (state_dbg !== 3'd0) begin
      bad++; $display("FAIL glitch_hold got=%0d want=0", state_dbg);
    end
    total++;
    if (sys_rst !== 1'b1 || fault_count !== 8'd0) begin
      bad++;
      $display("FAIL glitch_outputs got sys_rst=%0b faults=%0d want 1/0",
               sys_rst, fault_count);
    end
    pll_lock = 1'b1;
    wait_state(3'd3, 1'b1, 300, n);
    total++;
    if (n != LAT) begin
      bad++; $display("FAIL glitch_restart got=%0d want=%0d", n, LAT);
    end
    total++;
    if (fault_count !== 8'd0) begin
      bad++; $display("FAIL glitch_faults got=%0d want=0", fault_count);
    end
  endtask

  task automatic test_lock_loss();
    int n;
    pll_lock = 1'b0;
    wait_state(3'd4, 1'b1, 20, n);
    total++;
    if (n != 3 || sys_rst !== 1'b1) begin
      bad++;
      $display("FAIL loss_react got cycles=%0d sys_rst=%0b want 3/1",
               n, sys_rst);
    end
    wait_state(3'd4, 1'b0, 30, n);
    total++;
    if (n != FH || state_dbg !== 3'd0) begin
      bad++;
      $display("FAIL loss_hold got cycles=%0d state=%0d want %0d/0",
               n, state_dbg, FH);
    end
    total++;
    if (fault_count !== 8'd1) begin
      bad++; $display("FAIL loss_faults got=%0d want=1", fault_count);
    end
    pll_lock = 1'b1;
    wait_state(3'd3, 1'b1, 300, n);
    total++;
    if (n != LAT || last_edges !== 16'd24) begin
      bad++;
      $display("FAIL loss_recover got cycles=%0d last=%0d want %0d/24",
               n, last_edges, LAT);
    end
  endtask

  task automatic test_drift();
    int n;
    int f0;
    f0 = int'(fault_count);
    rate = 16;
    wait_state(3'd4, 1'b1, 300, n);
    total++;
    if (n < 0 || int'(fault_count) != f0 + 1) begin
      bad++;
      $display("FAIL slow_fault got cycles=%0d faults=%0d want >0/%0d",
               n, fault_count, f0 + 1);
    end
    total++;
    if (int'(last_edges) != m_last || last_edges >= 16'(EMIN)) begin
      bad++;
      $display("FAIL slow_last got=%0d want=%0d (<%0d)",
               last_edges, m_last, EMIN);
    end
    wait_state(3'd4, 1'b0, 30, n);
    wait_state(3'd4, 1'b1, 300, n);
    total++;
    if (n < 0 || last_edges !== 16'd16 || int'(fault_count) != f0 + 2) begin
      bad++;
      $display("FAIL slow_retry got last=%0d faults=%0d want 16/%0d",
               last_edges, fault_count, f0 + 2);
    end
    rate = 24;
    wait_state(3'd3, 1'b1, 300, n);
    total++;
    if (n < 0) begin
      bad++; $display("FAIL drift_rerun got=timeout want=RUN");
    end
    f0 = int'(fault_count);
    rate = 40;
    wait_state(3'd4, 1'b1, 300, n);
    total++;
    if (n < 0 || int'(last_edges) != m_last || last_edges <= 16'(EMAX)) begin
      bad++;
      $display("FAIL fast_fault got cycles=%0d last=%0d want >0/%0d",
               n, last_edges, m_last);
    end
    wait_state(3'd4, 1'b0, 30, n);
    wait_state(3'd4, 1'b1, 300, n);
    total++;
    if (n < 0 || last_edges !== 16'd40 || int'(fault_count) != f0 + 2) begin
      bad++;
      $display("FAIL fast_retry got last=%0d faults=%0d want 40/%0d",
               last_edges, fault_count, f0 + 2);
    end
  endtask

  task automatic test_boundary();
    int n;
    int left;
    int f0;
    rate = EMIN;
    wait_state(3'd3, 1'b1, 300, n);
    total++;
    if (n < 0 || last_edges !== 16'(EMIN)) begin
      bad++;
      $display("FAIL min_enter got cycles=%0d last=%0d want >0/%0d",
               n, last_edges, EMIN);
    end
    f0 = int'(fault_count);
    left = 0;
    repeat (3 * WIN) begin
      @(negedge clk);
      if (state_dbg != 3'd3) left++;
    end
    total++;
    if (left != 0 || last_edges !== 16'(EMIN)) begin
      bad++;
      $display("FAIL min_hold got off_cycles=%0d last=%0d want 0/%0d",
               left, last_edges, EMIN);
    end
    rate = EMAX;
    left = 0;
    repeat (3 * WIN) begin
      @(negedge clk);
      if (state_dbg != 3'd3) left++;
    end
    total++;
    if (left != 0 || last_edges !== 16'(EMAX)) begin
      bad++;
      $display("FAIL max_hold got off_cycles=%0d last=%0d want 0/%0d",
               left, last_edges, EMAX);
    end
    total++;
    if (int'(fault_count) != f0 || int'(state_dbg) != m_st) begin
      bad++;
      $display("FAIL bound_model got faults=%0d state=%0d want %0d/%0d",
               fault_count, state_dbg, f0, m_st);
    end
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 12; it++) begin
      rate = $urandom_range(34, 14);
      for (int ph = 0; ph < 2; ph++) begin
        pll_lock = (ph == 0);
        n = (ph == 0) ? $urandom_range(400, 40) : $urandom_range(12, 1);
        for (int c = 0; c < n; c++) begin
          @(negedge clk);
          total++;
          if (int'(state_dbg) != m_st ||
              sys_rst !== (m_st != 3) || ready !== (m_st == 3)) begin
            bad++;
            $display("FAIL rand_state got st=%0d rst=%0b rdy=%0b want st=%0d",
                     state_dbg, sys_rst, ready, m_st);
          end
          total++;
          if (int'(fault_count) != m_faults || int'(last_edges) != m_last) begin
            bad++;
            $display("FAIL rand_counts got f=%0d l=%0d want f=%0d l=%0d",
                     fault_count, last_edges, m_faults, m_last);
          end
        end
      end
    end
    pll_lock = 1'b1;
  endtask

  task automatic test_saturation();
    int entries;
    logic [2:0] prev;
    pll_lock = 1'b1;
    rate = 0;
    entries = 0;
    prev = state_dbg;
    for (int i = 0; i < 40000 && entries < 300; i++) begin
      @(negedge clk);
      if (state_dbg == 3'd4 && prev != 3'd4) entries++;
      prev = state_dbg;
    end
    total++;
    if (entries != 300) begin
      bad++; $display("FAIL sat_entries got=%0d want=300", entries);
    end
    total++;
    if (fault_count !== 8'd255 || m_faults != 255) begin
      bad++;
      $display("FAIL sat_count got=%0d model=%0d want=255",
               fault_count, m_faults);
    end
  endtask

  task automatic test_rst_mid_run();
    int n;
    rate = 24;
    wait_state(3'd3, 1'b1, 400, n);
    total++;
    if (n < 0) begin
      bad++; $display("FAIL mid_run_reach got=timeout want=RUN");
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (sys_rst !== 1'b1 || ready !== 1'b0 || state_dbg !== 3'd0) begin
      bad++;
      $display("FAIL mid_rst_ctl got rst=%0b rdy=%0b st=%0d want 1/0/0",
               sys_rst, ready, state_dbg);
    end
    total++;
    if (fault_count !== 8'd0 || last_edges !== '0) begin
      bad++;
      $display("FAIL mid_rst_cnt got f=%0d l=%0d want 0/0",
               fault_count, last_edges);
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clean_start();
    test_lock_glitch();
    test_lock_loss();
    test_drift();
    test_boundary();
    test_random();
    test_saturation();
    test_rst_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
